// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-stage access unit: size encodings,
// FSM state type and byte-enable generation (big-endian lane order).
package mem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    // Byte offset k maps to enable bit nb-1-k; result is right-justified in 8 bits
    function automatic logic [7:0] be_gen(input logic [1:0] size,
                                          input logic [2:0] off,
                                          input int unsigned nb);
        logic [7:0] ones;
        int         sh;
        case (size)
            SZ_B:    ones = 8'h01;
            SZ_H:    ones = 8'h03;
            SZ_W:    ones = 8'h0F;
            default: ones = 8'hFF;
        endcase
        sh = int'(nb) - int'(off) - (1 << size);
        if (sh < 0) sh = 0;
        return ones << sh;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-bus request/response interface between the access unit (master)
// and the memory system (slave).
interface mem_access_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    localparam int NB = DATA_W / 8;

    logic              bus_req_o;
    logic              bus_wr_o;
    logic [NB-1:0]     bus_be_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [DATA_W-1:0] bus_wdata_o;
    logic              bus_addr_ok_i;
    logic              bus_data_ok_i;
    logic [DATA_W-1:0] bus_rdata_i;

    modport master (
        output bus_req_o, bus_wr_o, bus_be_o, bus_addr_o, bus_wdata_o,
        input  bus_addr_ok_i, bus_data_ok_i, bus_rdata_i
    );

    modport slave (
        input  bus_req_o, bus_wr_o, bus_be_o, bus_addr_o, bus_wdata_o,
        output bus_addr_ok_i, bus_data_ok_i, bus_rdata_i
    );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane handling: store-data replication across all byte
// lanes and load-data extraction with sign/zero extension (big-endian).
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]                     st_size_i,
    input  logic [DATA_W-1:0]              st_data_i,
    output logic [DATA_W-1:0]              st_data_o,
    input  logic [1:0]                     ld_size_i,
    input  logic                           ld_zext_i,
    input  logic [$clog2(DATA_W/8)-1:0]    ld_off_i,
    input  logic [DATA_W-1:0]              ld_data_i,
    output logic [DATA_W-1:0]              ld_data_o
);
    localparam int NB = DATA_W / 8;

    int                w_nbits;
    int                w_sh;
    logic [DATA_W-1:0] w_shifted;
    logic [DATA_W-1:0] w_mask;
    logic [DATA_W-1:0] w_top;

    // Replicate the low 2^size bytes of the store data over every lane
    always_comb begin
        st_data_o = st_data_i;
        case (st_size_i)
            SZ_B:    st_data_o = {NB{st_data_i[7:0]}};
            SZ_H:    st_data_o = {(NB/2){st_data_i[15:0]}};
            SZ_W:    st_data_o = {(NB/4){st_data_i[31:0]}};
            default: st_data_o = st_data_i;
        endcase
    end

    // Shift the addressed lanes down to bit 0, then mask and extend
    always_comb begin
        w_nbits = 8 << ld_size_i;
        if (w_nbits > DATA_W) w_nbits = DATA_W;
        w_sh = DATA_W - 8 * int'(ld_off_i) - w_nbits;
        if (w_sh < 0) w_sh = 0;
        w_shifted = ld_data_i >> w_sh;
        w_mask    = {DATA_W{1'b1}} >> (DATA_W - w_nbits);
        w_top     = w_mask & ~(w_mask >> 1);
        ld_data_o = w_shifted & w_mask;
        if (!ld_zext_i && (|(w_shifted & w_top)))
            ld_data_o = ld_data_o | ~w_mask;
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage data access unit: accepts a load/store from EX/MEM, issues
// it on a request/response bus, stalls the pipeline until the response and
// returns extended load data with a one-cycle done pulse.
// Optional macro MEM_ALIGN_CHECK_EN: when defined, misaligned accesses are
// flagged on addr_err_o and not issued; otherwise they are force-aligned.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_i,
    input  logic                mem_read_i,
    input  logic                mem_write_i,
    input  logic [2:0]          mem_type_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic                flush_i,
    output logic                stall_o,
    output logic                done_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                addr_err_o,
    mem_access_unit_if.master   bus
);
    localparam int NB   = DATA_W / 8;
    localparam int OFFW = $clog2(NB);

    state_t            r_state, w_next;
    logic [1:0]        r_size;
    logic              r_zext;
    logic [OFFW-1:0]   r_off;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [NB-1:0]     r_be;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;

    logic [1:0]        w_size;
    logic              w_access;
    logic [OFFW-1:0]   w_off_raw;
    logic [OFFW-1:0]   w_off;
    logic [OFFW-1:0]   w_lowmask;
    logic              w_illegal;
    logic              w_addr_err;
    logic              w_accept;
    logic [NB-1:0]     w_be;
    logic [DATA_W-1:0] w_wdata_rep;
    logic [DATA_W-1:0] w_ld_data;

    assign w_size    = mem_type_i[1:0];
    assign w_access  = mem_read_i | mem_write_i;
    assign w_off_raw = addr_i[OFFW-1:0];
    assign w_lowmask = OFFW'((32'd1 << w_size) - 32'd1);
    assign w_illegal = (w_size == SZ_D) && (NB == 4);

`ifdef MEM_ALIGN_CHECK_EN
    logic w_misalign;
    assign w_misalign = |(w_off_raw & w_lowmask);
    assign w_addr_err = w_illegal | w_misalign;
    assign w_off      = w_off_raw;
    assign addr_err_o = rst & valid_i & w_access & w_addr_err;
`else
    assign w_addr_err = w_illegal;
    assign w_off      = w_off_raw & ~w_lowmask;
    assign addr_err_o = 1'b0;
`endif

    // rst gating keeps stall_o low while reset is held with valid_i still high
    assign w_accept = rst & (r_state == IDLE) & valid_i & w_access & ~flush_i & ~w_addr_err;
    assign w_be     = NB'(be_gen(w_size, 3'(w_off), NB));

    mem_lane_align #(.DATA_W(DATA_W)) u_align (
        .st_size_i (w_size),
        .st_data_i (wdata_i),
        .st_data_o (w_wdata_rep),
        .ld_size_i (r_size),
        .ld_zext_i (r_zext),
        .ld_off_i  (r_off),
        .ld_data_i (bus.bus_rdata_i),
        .ld_data_o (w_ld_data)
    );

    // Next-state logic; a response arriving together with a flush is
    // simply discarded instead of entering DRAIN, which would wait forever
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (w_accept) w_next = REQ;
            REQ: begin
                if (bus.bus_addr_ok_i) begin
                    if (bus.bus_data_ok_i) w_next = flush_i ? IDLE : DONE;
                    else                   w_next = flush_i ? DRAIN : WAIT;
                end else if (flush_i) begin
                    w_next = IDLE;
                end
            end
            WAIT: begin
                if (bus.bus_data_ok_i) w_next = flush_i ? IDLE : DONE;
                else if (flush_i)      w_next = DRAIN;
            end
            DONE:  w_next = IDLE;
            DRAIN: if (bus.bus_data_ok_i) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register, access capture on accept, load-data capture on completion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_size  <= '0;
            r_zext  <= 1'b0;
            r_off   <= '0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_size  <= w_size;
                r_zext  <= mem_type_i[2];
                r_off   <= w_off;
                r_wr    <= mem_write_i;
                r_addr  <= {addr_i[ADDR_W-1:OFFW], {OFFW{1'b0}}};
                r_be    <= mem_write_i ? w_be : '0;
                r_wdata <= w_wdata_rep;
            end
            if ((w_next == DONE) && !r_wr)
                r_rdata <= w_ld_data;
        end
    end

    assign stall_o         = w_accept | (r_state == REQ) | (r_state == WAIT) | (r_state == DRAIN);
    assign done_o          = (r_state == DONE);
    assign rdata_o         = r_rdata;
    assign bus.bus_req_o   = (r_state == REQ);
    assign bus.bus_wr_o    = r_wr & (r_state == REQ);
    assign bus.bus_be_o    = r_be;
    assign bus.bus_addr_o  = r_addr;
    assign bus.bus_wdata_o = r_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a 32-bit and a 64-bit instance,
// expected bus requests and load results queued at drive time and checked
// when the DUT presents them. Honours MEM_ALIGN_CHECK_EN if defined.
module tb_mem_access_unit;

    typedef struct {
        logic        wr;
        logic [7:0]  be;
        logic [31:0] addr;
        logic [63:0] wdata;
    } bus_exp_t;

    bus_exp_t    bus_q[$];
    logic [63:0] rd_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        v32 = 0, rd32 = 0, wr32 = 0, fl32 = 0;
    logic [2:0]  ty32 = '0;
    logic [31:0] a32 = '0, wd32 = '0;
    logic        st32, dn32, ae32;
    logic [31:0] ro32;

    logic        v64 = 0, rd64 = 0, wr64 = 0, fl64 = 0;
    logic [2:0]  ty64 = '0;
    logic [31:0] a64 = '0;
    logic [63:0] wd64 = '0;
    logic        st64, dn64, ae64;
    logic [63:0] ro64;

    mem_access_unit_if #(.DATA_W(32), .ADDR_W(32)) b32 ();
    mem_access_unit_if #(.DATA_W(64), .ADDR_W(32)) b64 ();

    mem_access_unit #(.DATA_W(32), .ADDR_W(32)) u32 (
        .clk(clk), .rst(rst), .valid_i(v32), .mem_read_i(rd32), .mem_write_i(wr32),
        .mem_type_i(ty32), .addr_i(a32), .wdata_i(wd32), .flush_i(fl32),
        .stall_o(st32), .done_o(dn32), .rdata_o(ro32), .addr_err_o(ae32), .bus(b32.master)
    );

    mem_access_unit #(.DATA_W(64), .ADDR_W(32)) u64 (
        .clk(clk), .rst(rst), .valid_i(v64), .mem_read_i(rd64), .mem_write_i(wr64),
        .mem_type_i(ty64), .addr_i(a64), .wdata_i(wd64), .flush_i(fl64),
        .stall_o(st64), .done_o(dn64), .rdata_o(ro64), .addr_err_o(ae64), .bus(b64.master)
    );

    task automatic test_reset;
        b32.bus_addr_ok_i = 0; b32.bus_data_ok_i = 0; b32.bus_rdata_i = '0;
        b64.bus_addr_ok_i = 0; b64.bus_data_ok_i = 0; b64.bus_rdata_i = '0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (st32 !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", st32); end
        n_vec++; if (dn32 !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", dn32); end
        n_vec++; if (ae32 !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", ae32); end
        n_vec++; if (ro32 !== 32'h0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", ro32); end
        n_vec++; if (b32.bus_req_o !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", b32.bus_req_o); end
        n_vec++; if (b32.bus_wr_o !== 1'b0) begin n_err++; $display("FAIL rst_wr: got %b want 0", b32.bus_wr_o); end
        n_vec++; if (b32.bus_be_o !== 4'h0) begin n_err++; $display("FAIL rst_be: got %h want 0", b32.bus_be_o); end
        n_vec++; if (b32.bus_addr_o !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h want 0", b32.bus_addr_o); end
        n_vec++; if (b32.bus_wdata_o !== 32'h0) begin n_err++; $display("FAIL rst_wdata: got %h want 0", b32.bus_wdata_o); end
        n_vec++; if (ro64 !== 64'h0 || b64.bus_req_o !== 1'b0 || st64 !== 1'b0)
            begin n_err++; $display("FAIL rst_64: got rdata %h req %b stall %b want 0", ro64, b64.bus_req_o, st64); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Full 32-bit access; addr_ok in REQ cycle a_dly (0-based), data_ok d_dly cycles later
    task automatic access32(input logic is_wr, input logic [2:0] ty, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rsp, input int a_dly, input int d_dly,
                            input logic [3:0] e_be, input logic [31:0] e_addr, input logic [31:0] e_wdata,
                            input logic [31:0] e_rdata);
        bus_exp_t    e;
        logic [63:0] er;
        int          stalls;
        @(negedge clk);
        v32 = 1; rd32 = !is_wr; wr32 = is_wr; ty32 = ty; a32 = addr; wd32 = wd;
        e.wr = is_wr; e.be = {4'h0, e_be}; e.addr = e_addr; e.wdata = {32'h0, e_wdata};
        bus_q.push_back(e);
        rd_q.push_back({32'h0, e_rdata});
        #1;
        n_vec++; if (st32 !== 1'b1) begin n_err++; $display("FAIL accept_stall @%h: got %b want 1", addr, st32); end
        n_vec++; if (ae32 !== 1'b0) begin n_err++; $display("FAIL accept_err @%h: got %b want 0", addr, ae32); end
        stalls = 1;
        for (int c = 0; c <= a_dly; c++) begin
            @(posedge clk); #1;
            n_vec++; if (b32.bus_req_o !== 1'b1) begin n_err++; $display("FAIL bus_req @%h: got %b want 1", addr, b32.bus_req_o); end
            if (c == 0) begin
                e = bus_q.pop_front();
                n_vec++; if (b32.bus_be_o !== e.be[3:0]) begin n_err++; $display("FAIL bus_be @%h: got %b want %b", addr, b32.bus_be_o, e.be[3:0]); end
                n_vec++; if (b32.bus_addr_o !== e.addr) begin n_err++; $display("FAIL bus_addr @%h: got %h want %h", addr, b32.bus_addr_o, e.addr); end
                n_vec++; if (b32.bus_wr_o !== e.wr) begin n_err++; $display("FAIL bus_wr @%h: got %b want %b", addr, b32.bus_wr_o, e.wr); end
                if (e.wr) begin
                    n_vec++; if (b32.bus_wdata_o !== e.wdata[31:0]) begin n_err++; $display("FAIL bus_wdata @%h: got %h want %h", addr, b32.bus_wdata_o, e.wdata[31:0]); end
                end
            end
            if (st32) stalls++;
            if (c == a_dly) begin
                b32.bus_addr_ok_i = 1; b32.bus_data_ok_i = (d_dly == 0); b32.bus_rdata_i = rsp;
            end
        end
        for (int w = 1; w <= d_dly; w++) begin
            @(posedge clk); #1;
            b32.bus_addr_ok_i = 0; b32.bus_data_ok_i = 0; b32.bus_rdata_i = $urandom;
            n_vec++; if (b32.bus_req_o !== 1'b0) begin n_err++; $display("FAIL wait_req @%h: got %b want 0", addr, b32.bus_req_o); end
            if (st32) stalls++;
            if (w == d_dly) begin b32.bus_data_ok_i = 1; b32.bus_rdata_i = rsp; end
        end
        @(posedge clk); #1;
        b32.bus_addr_ok_i = 0; b32.bus_data_ok_i = 0; b32.bus_rdata_i = $urandom;
        er = rd_q.pop_front();
        n_vec++; if (dn32 !== 1'b1) begin n_err++; $display("FAIL done @%h: got %b want 1", addr, dn32); end
        n_vec++; if (st32 !== 1'b0) begin n_err++; $display("FAIL done_stall @%h: got %b want 0", addr, st32); end
        n_vec++; if (stalls !== 2 + a_dly + d_dly) begin n_err++; $display("FAIL stall_cycles @%h: got %0d want %0d", addr, stalls, 2 + a_dly + d_dly); end
        if (!is_wr) begin
            n_vec++; if (ro32 !== er[31:0]) begin n_err++; $display("FAIL rdata @%h: got %h want %h", addr, ro32, er[31:0]); end
        end
        @(negedge clk);
        v32 = 0; rd32 = 0; wr32 = 0;
        @(posedge clk); #1;
        n_vec++; if (dn32 !== 1'b0) begin n_err++; $display("FAIL done_width @%h: got %b want 0", addr, dn32); end
    endtask

    // 64-bit access with addr_ok on the first REQ cycle and data_ok one cycle later
    task automatic access64(input logic is_wr, input logic [2:0] ty, input logic [31:0] addr,
                            input logic [63:0] wd, input logic [63:0] rsp, input logic [7:0] e_be,
                            input logic [31:0] e_addr, input logic [63:0] e_wdata, input logic [63:0] e_rdata);
        bus_exp_t    e;
        logic [63:0] er;
        @(negedge clk);
        v64 = 1; rd64 = !is_wr; wr64 = is_wr; ty64 = ty; a64 = addr; wd64 = wd;
        e.wr = is_wr; e.be = e_be; e.addr = e_addr; e.wdata = e_wdata;
        bus_q.push_back(e);
        rd_q.push_back(e_rdata);
        #1;
        n_vec++; if (st64 !== 1'b1) begin n_err++; $display("FAIL d64_accept @%h: got %b want 1", addr, st64); end
        @(posedge clk); #1;
        e = bus_q.pop_front();
        n_vec++; if (b64.bus_req_o !== 1'b1) begin n_err++; $display("FAIL d64_req @%h: got %b want 1", addr, b64.bus_req_o); end
        n_vec++; if (b64.bus_be_o !== e.be) begin n_err++; $display("FAIL d64_be @%h: got %b want %b", addr, b64.bus_be_o, e.be); end
        n_vec++; if (b64.bus_addr_o !== e.addr) begin n_err++; $display("FAIL d64_addr @%h: got %h want %h", addr, b64.bus_addr_o, e.addr); end
        if (e.wr) begin
            n_vec++; if (b64.bus_wdata_o !== e.wdata) begin n_err++; $display("FAIL d64_wdata @%h: got %h want %h", addr, b64.bus_wdata_o, e.wdata); end
        end
        b64.bus_addr_ok_i = 1;
        @(posedge clk); #1;
        b64.bus_addr_ok_i = 0;
        n_vec++; if (st64 !== 1'b1 || dn64 !== 1'b0) begin n_err++; $display("FAIL d64_wait @%h: got stall %b done %b want 1 0", addr, st64, dn64); end
        b64.bus_data_ok_i = 1; b64.bus_rdata_i = rsp;
        @(posedge clk); #1;
        b64.bus_data_ok_i = 0; b64.bus_rdata_i = '0;
        er = rd_q.pop_front();
        n_vec++; if (dn64 !== 1'b1) begin n_err++; $display("FAIL d64_done @%h: got %b want 1", addr, dn64); end
        if (!is_wr) begin
            n_vec++; if (ro64 !== er) begin n_err++; $display("FAIL d64_rdata @%h: got %h want %h", addr, ro64, er); end
        end
        @(negedge clk);
        v64 = 0; rd64 = 0; wr64 = 0;
    endtask

    task automatic test_basic32;
        access32(1, 3'b000, 32'h103, 32'h0000_00AB, 32'h0, 1, 1, 4'b0001, 32'h100, 32'hABAB_ABAB, 32'h0);
        access32(0, 3'b001, 32'h002, 32'h0, 32'h1234_F00D, 0, 0, 4'b0000, 32'h000, 32'h0, 32'hFFFF_F00D);
        access32(0, 3'b101, 32'h002, 32'h0, 32'h1234_F00D, 0, 0, 4'b0000, 32'h000, 32'h0, 32'h0000_F00D);
        access32(0, 3'b000, 32'h041, 32'h0, 32'h1285_5678, 2, 0, 4'b0000, 32'h040, 32'h0, 32'hFFFF_FF85);
        access32(1, 3'b001, 32'h022, 32'h1234_BEEF, 32'h0, 0, 2, 4'b0011, 32'h020, 32'hBEEF_BEEF, 32'h0);
        access32(1, 3'b010, 32'h044, 32'hCAFE_F00D, 32'h0, 0, 0, 4'b1111, 32'h044, 32'hCAFE_F00D, 32'h0);
        access32(0, 3'b110, 32'h008, 32'h0, 32'h89AB_CDEF, 1, 0, 4'b0000, 32'h008, 32'h0, 32'h89AB_CDEF);
        access32(0, 3'b100, 32'h003, 32'h0, 32'h1122_33C3, 0, 1, 4'b0000, 32'h000, 32'h0, 32'h0000_00C3);
    endtask

    task automatic test_flush_wait;
        bus_exp_t e;
        @(negedge clk);
        v32 = 1; rd32 = 1; wr32 = 0; ty32 = 3'b010; a32 = 32'h10;
        e.wr = 0; e.be = 8'h0; e.addr = 32'h10; e.wdata = '0;
        bus_q.push_back(e);
        @(posedge clk); #1;
        e = bus_q.pop_front();
        n_vec++; if (b32.bus_addr_o !== e.addr) begin n_err++; $display("FAIL flw_addr: got %h want %h", b32.bus_addr_o, e.addr); end
        b32.bus_addr_ok_i = 1;
        @(posedge clk); #1;
        b32.bus_addr_ok_i = 0; fl32 = 1; v32 = 0; rd32 = 0;
        @(posedge clk); #1;
        fl32 = 0;
        for (int i = 0; i < 2; i++) begin
            n_vec++; if (st32 !== 1'b1) begin n_err++; $display("FAIL drain_stall%0d: got %b want 1", i, st32); end
            n_vec++; if (dn32 !== 1'b0) begin n_err++; $display("FAIL drain_done%0d: got %b want 0", i, dn32); end
            if (i == 1) begin b32.bus_data_ok_i = 1; b32.bus_rdata_i = 32'h5555_5555; end
            @(posedge clk); #1;
        end
        b32.bus_data_ok_i = 0;
        n_vec++; if (st32 !== 1'b0 || dn32 !== 1'b0) begin n_err++; $display("FAIL drain_exit: got stall %b done %b want 0 0", st32, dn32); end
        n_vec++; if (ro32 !== 32'h0000_00C3) begin n_err++; $display("FAIL rdata_hold: got %h want 000000c3", ro32); end
        access32(0, 3'b010, 32'h0C, 32'h0, 32'h0BAD_CAFE, 0, 0, 4'b0000, 32'h00C, 32'h0, 32'h0BAD_CAFE);
    endtask

    task automatic test_flush_req;
        bus_exp_t e;
        @(negedge clk);
        v32 = 1; wr32 = 1; rd32 = 0; ty32 = 3'b010; a32 = 32'h80; wd32 = 32'h1;
        e.wr = 1; e.be = 8'h0F; e.addr = 32'h80; e.wdata = 64'h1;
        bus_q.push_back(e);
        @(posedge clk); #1;
        e = bus_q.pop_front();
        n_vec++; if (b32.bus_be_o !== e.be[3:0]) begin n_err++; $display("FAIL flr_be: got %b want %b", b32.bus_be_o, e.be[3:0]); end
        fl32 = 1; v32 = 0; wr32 = 0;
        @(posedge clk); #1;
        fl32 = 0;
        n_vec++; if (b32.bus_req_o !== 1'b0 || st32 !== 1'b0) begin n_err++; $display("FAIL flr_drop: got req %b stall %b want 0 0", b32.bus_req_o, st32); end
        @(posedge clk); #1;
        n_vec++; if (dn32 !== 1'b0) begin n_err++; $display("FAIL flr_done: got %b want 0", dn32); end
    endtask

    task automatic test_misalign;
`ifdef MEM_ALIGN_CHECK_EN
        @(negedge clk);
        v32 = 1; rd32 = 1; ty32 = 3'b010; a32 = 32'h6;
        #1;
        n_vec++; if (ae32 !== 1'b1) begin n_err++; $display("FAIL mis_err: got %b want 1", ae32); end
        n_vec++; if (st32 !== 1'b0) begin n_err++; $display("FAIL mis_stall: got %b want 0", st32); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_vec++; if (b32.bus_req_o !== 1'b0 || dn32 !== 1'b0) begin n_err++; $display("FAIL mis_req%0d: got req %b done %b want 0 0", i, b32.bus_req_o, dn32); end
        end
        v32 = 0; rd32 = 0;
        #1;
        n_vec++; if (ae32 !== 1'b0) begin n_err++; $display("FAIL mis_err_clear: got %b want 0", ae32); end
`else
        access32(0, 3'b010, 32'h006, 32'h0, 32'hDEAD_BEEF, 0, 0, 4'b0000, 32'h004, 32'h0, 32'hDEAD_BEEF);
`endif
    endtask

    task automatic test_illegal_size;
        logic e_err;
`ifdef MEM_ALIGN_CHECK_EN
        e_err = 1'b1;
`else
        e_err = 1'b0;
`endif
        @(negedge clk);
        v32 = 1; rd32 = 1; ty32 = 3'b011; a32 = 32'h0;
        #1;
        n_vec++; if (ae32 !== e_err) begin n_err++; $display("FAIL ill_err: got %b want %b", ae32, e_err); end
        n_vec++; if (st32 !== 1'b0) begin n_err++; $display("FAIL ill_stall: got %b want 0", st32); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_vec++; if (b32.bus_req_o !== 1'b0) begin n_err++; $display("FAIL ill_req%0d: got %b want 0", i, b32.bus_req_o); end
        end
        @(negedge clk);
        v32 = 0; rd32 = 0;
    endtask

    task automatic test_reset_mid;
        bus_exp_t e;
        @(negedge clk);
        v32 = 1; rd32 = 1; ty32 = 3'b010; a32 = 32'h200;
        e.wr = 0; e.be = 8'h0; e.addr = 32'h200; e.wdata = '0;
        bus_q.push_back(e);
        @(posedge clk); #1;
        e = bus_q.pop_front();
        n_vec++; if (b32.bus_req_o !== 1'b1 || b32.bus_addr_o !== e.addr)
            begin n_err++; $display("FAIL rm_req: got req %b addr %h want 1 %h", b32.bus_req_o, b32.bus_addr_o, e.addr); end
        #2 rst = 1'b0;
        #1;
        n_vec++; if (b32.bus_req_o !== 1'b0) begin n_err++; $display("FAIL rm_req_async: got %b want 0", b32.bus_req_o); end
        n_vec++; if (st32 !== 1'b0) begin n_err++; $display("FAIL rm_stall_async: got %b want 0", st32); end
        @(negedge clk);
        v32 = 0; rd32 = 0; rst = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (b32.bus_req_o !== 1'b0 || st32 !== 1'b0 || dn32 !== 1'b0)
            begin n_err++; $display("FAIL rm_idle: got req %b stall %b done %b want 0 0 0", b32.bus_req_o, st32, dn32); end
        access32(1, 3'b000, 32'h201, 32'h0000_0077, 32'h0, 0, 0, 4'b0100, 32'h200, 32'h7777_7777, 32'h0);
    endtask

    task automatic test_dw64;
        access64(0, 3'b011, 32'h008, 64'h0, 64'h0123_4567_89AB_CDEF, 8'h00, 32'h008, 64'h0, 64'h0123_4567_89AB_CDEF);
        access64(1, 3'b000, 32'h005, 64'h5A, 64'h0, 8'b0000_0100, 32'h000, 64'h5A5A_5A5A_5A5A_5A5A, 64'h0);
        access64(0, 3'b010, 32'h014, 64'h0, 64'h0123_4567_89AB_CDEF, 8'h00, 32'h010, 64'h0, 64'hFFFF_FFFF_89AB_CDEF);
    endtask

    initial begin
        test_reset;
        test_basic32;
        test_flush_wait;
        test_flush_req;
        test_misalign;
        test_illegal_size;
        test_reset_mid;
        test_dw64;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
